// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between up to four requesters.
// Each accepted request is captured, executed for one cycle, then the
// registered result is held for the granted requester until it is taken.

module alu (
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    // Opcode decode; undefined opcodes produce zero
    always_comb begin
        y = '0;
        case (op)
            4'h0:    y = a + b;
            4'h1:    y = a << b[4:0];
            4'h2:    y = {31'b0, $signed(a) < $signed(b)};
            4'h3:    y = {31'b0, a < b};
            4'h4:    y = a ^ b;
            4'h5:    y = a >> b[4:0];
            4'h6:    y = a | b;
            4'h7:    y = a & b;
            4'h8:    y = a - b;
            4'hD:    y = 32'($signed(a) >>> b[4:0]);
            default: y = '0;
        endcase
    end

endmodule

module alu_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [4*NUM_REQ-1:0]   req_opr,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [31:0]            rsp_result,
    output logic                   rsp_illegal,
    output logic                   busy
);

    localparam int GW = 2;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state;
    state_t        next_state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] grant;
    logic [GW-1:0] pick;
    logic [GW-1:0] cand;
    logic          found;
    logic          accept;
    logic          rsp_taken;
    logic [3:0]    valid_ext;
    logic [3:0]    sel_opr;
    logic [31:0]   sel_a;
    logic [31:0]   sel_b;
    logic [3:0]    cap_opr;
    logic [31:0]   cap_a;
    logic [31:0]   cap_b;
    logic [31:0]   alu_y;
    logic          illegal_op;

    assign valid_ext = 4'(req_valid);

    // Round-robin search starting just above the previous winner
    always_comb begin
        found = 1'b0;
        pick  = last_grant;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = GW'((int'(last_grant) + i) % NUM_REQ);
            if (!found && valid_ext[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Operand mux selecting the winning requester's payload
    always_comb begin
        sel_opr = '0;
        sel_a   = '0;
        sel_b   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == GW'(i)) begin
                sel_opr = req_opr[4*i +: 4];
                sel_a   = req_a[32*i +: 32];
                sel_b   = req_b[32*i +: 32];
            end
        end
    end

    // Opcodes the ALU does not define are flagged alongside the result
    always_comb begin
        case (cap_opr)
            4'h9, 4'hA, 4'hB, 4'hC, 4'hE, 4'hF: illegal_op = 1'b1;
            default:                            illegal_op = 1'b0;
        endcase
    end

    alu u_alu (
        .op (cap_opr),
        .a  (cap_a),
        .b  (cap_b),
        .y  (alu_y)
    );

    // Only the granted requester's rsp_ready can complete the response
    assign rsp_taken = |(rsp_ready & rsp_valid);

    // FSM next-state and handshake outputs
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        req_ready  = '0;
        rsp_valid  = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (found && !rst) begin
                    accept     = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: next_state = RESP;
            RESP: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    rsp_valid[i] = (grant == GW'(i));
                end
                if (rsp_taken) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (pick == GW'(i));
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Capture on accept, register ALU output during EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= GW'(NUM_REQ - 1);
            grant       <= '0;
            cap_opr     <= '0;
            cap_a       <= '0;
            cap_b       <= '0;
            rsp_result  <= '0;
            rsp_illegal <= 1'b0;
        end else begin
            if (accept) begin
                cap_opr    <= sel_opr;
                cap_a      <= sel_a;
                cap_b      <= sel_b;
                grant      <= pick;
                last_grant <= pick;
            end
            if (state == EXEC) begin
                rsp_result  <= alu_y;
                rsp_illegal <= illegal_op;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard-driven bench for alu_arbiter with two requesters.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit later.

module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_opr;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_illegal;
    logic        busy;

    typedef struct {
        int          req;
        logic [31:0] result;
        logic        illegal;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] result;
        logic        illegal;
    } vec_t;

    exp_t sb[$];
    int   checks;
    int   failures;

    alu_arbiter #(.NUM_REQ(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opr     (req_opr),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_illegal (rsp_illegal),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_opr[4*i +: 4]  = op;
        req_a[32*i +: 32]  = a;
        req_b[32*i +: 32]  = b;
    endtask

    task test_reset;
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_opr   = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_handshake: got ready=%b valid=%b expected 00 00", req_ready, rsp_valid);
        end
        checks++;
        if (rsp_result !== 32'h0 || rsp_illegal !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got result=%h illegal=%b busy=%b expected 0 0 0", rsp_result, rsp_illegal, busy);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task test_add;
        exp_t e;
        @(negedge clk);
        set_req(0, 4'h0, 32'd5, 32'd7);
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("[TB] FAIL add_accept: got %b expected 01", req_ready);
        end
        sb.push_back('{0, 32'd12, 1'b0});
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 2'b00) begin
            failures++;
            $display("[TB] FAIL add_exec: got busy=%b valid=%b expected 1 00", busy, rsp_valid);
        end
        @(negedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (rsp_valid !== 2'(1 << e.req) || rsp_result !== e.result || rsp_illegal !== e.illegal) begin
            failures++;
            $display("[TB] FAIL add_resp: got valid=%b result=%h illegal=%b expected %b %h %b",
                     rsp_valid, rsp_result, rsp_illegal, 2'(1 << e.req), e.result, e.illegal);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL add_idle: got busy=%b expected 0", busy);
        end
    endtask

    task test_round_robin;
        int   grants[$];
        int   gcyc[$];
        int   g;
        exp_t e;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 4'h0, 32'd10, 32'd20);
        set_req(1, 4'h8, 32'd100, 32'd1);
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        #1;
        for (int i = 0; i < 12; i++) begin
            if (req_ready != 2'b00) begin
                g = req_ready[1] ? 1 : 0;
                grants.push_back(g);
                gcyc.push_back(i);
                sb.push_back('{g, (g == 0) ? 32'd30 : 32'd99, 1'b0});
            end
            if (rsp_valid != 2'b00) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL rr_resp: got valid=%b expected no response", rsp_valid);
                end else begin
                    e = sb.pop_front();
                    if (rsp_valid !== 2'(1 << e.req) || rsp_result !== e.result) begin
                        failures++;
                        $display("[TB] FAIL rr_resp: got valid=%b result=%h expected %b %h",
                                 rsp_valid, rsp_result, 2'(1 << e.req), e.result);
                    end
                end
            end
            @(negedge clk);
            if (i == 11) req_valid = 2'b00;
            #1;
        end
        checks++;
        if (grants.size() != 4) begin
            failures++;
            $display("[TB] FAIL rr_count: got %0d grants expected 4", grants.size());
        end
        for (int k = 0; k < grants.size() && k < 4; k++) begin
            checks++;
            if (grants[k] != k % 2) begin
                failures++;
                $display("[TB] FAIL rr_order: grant %0d got requester %0d expected %0d", k, grants[k], k % 2);
            end
            if (k > 0) begin
                checks++;
                if (gcyc[k] - gcyc[k-1] != 3) begin
                    failures++;
                    $display("[TB] FAIL rr_spacing: grant %0d got gap %0d expected 3", k, gcyc[k] - gcyc[k-1]);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL rr_drain: got %0d pending expected 0", sb.size());
        end
        sb.delete();
    endtask

    task test_backpressure;
        exp_t e;
        int   n;
        @(negedge clk);
        set_req(1, 4'h8, 32'd3, 32'd5);
        set_req(0, 4'h0, 32'd1, 32'd2);
        req_valid = 2'b10;
        rsp_ready = 2'b00;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            failures++;
            $display("[TB] FAIL bp_accept: got %b expected 10", req_ready);
        end
        sb.push_back('{1, 32'hFFFF_FFFE, 1'b0});
        @(negedge clk);
        req_valid = 2'b01;
        #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rsp_ready = 2'b01;
            #1;
            checks++;
            if (rsp_valid !== 2'b10 || rsp_result !== 32'hFFFF_FFFE || req_ready !== 2'b00) begin
                failures++;
                $display("[TB] FAIL bp_hold: cycle %0d got valid=%b result=%h ready=%b expected 10 fffffffe 00",
                         k, rsp_valid, rsp_result, req_ready);
            end
        end
        @(negedge clk);
        rsp_ready = 2'b10;
        #1;
        e = sb.pop_front();
        checks++;
        if (rsp_valid !== 2'(1 << e.req) || rsp_result !== e.result || req_ready !== 2'b00) begin
            failures++;
            $display("[TB] FAIL bp_release: got valid=%b result=%h ready=%b expected %b %h 00",
                     rsp_valid, rsp_result, req_ready, 2'(1 << e.req), e.result);
        end
        @(negedge clk);
        rsp_ready = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("[TB] FAIL bp_next_grant: got %b expected 01", req_ready);
        end
        sb.push_back('{0, 32'd3, 1'b0});
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n = 0;
        while (rsp_valid == 2'b00 && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        e = sb.pop_front();
        checks++;
        if (rsp_valid !== 2'(1 << e.req) || rsp_result !== e.result) begin
            failures++;
            $display("[TB] FAIL bp_second: got valid=%b result=%h expected %b %h",
                     rsp_valid, rsp_result, 2'(1 << e.req), e.result);
        end
    endtask

    task test_shift_compare;
        vec_t tbl[4];
        exp_t e;
        int   n;
        tbl[0] = '{4'hD, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0};
        tbl[1] = '{4'h5, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0};
        tbl[2] = '{4'h2, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0};
        tbl[3] = '{4'h3, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0};
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            set_req(0, tbl[t].op, tbl[t].a, tbl[t].b);
            req_valid = 2'b01;
            rsp_ready = 2'b11;
            #1;
            n = 0;
            while (req_ready[0] !== 1'b1 && n < 8) begin
                @(negedge clk);
                #1;
                n++;
            end
            checks++;
            if (req_ready[0] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL shift_accept_%0d: got ready=%b expected 01", t, req_ready);
            end else begin
                sb.push_back('{0, tbl[t].result, tbl[t].illegal});
            end
            @(negedge clk);
            req_valid = 2'b00;
            #1;
            n = 0;
            while (rsp_valid == 2'b00 && n < 8) begin
                @(negedge clk);
                #1;
                n++;
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (rsp_valid !== 2'(1 << e.req) || rsp_result !== e.result || rsp_illegal !== e.illegal) begin
                    failures++;
                    $display("[TB] FAIL shift_resp_%0d: got valid=%b result=%h illegal=%b expected %b %h %b",
                             t, rsp_valid, rsp_result, rsp_illegal, 2'(1 << e.req), e.result, e.illegal);
                end
            end
        end
    endtask

    task test_illegal;
        vec_t tbl[2];
        exp_t e;
        int   n;
        tbl[0] = '{4'hF, 32'd1, 32'd1, 32'd0, 1'b1};
        tbl[1] = '{4'h0, 32'd2, 32'd3, 32'd5, 1'b0};
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            set_req(0, tbl[t].op, tbl[t].a, tbl[t].b);
            req_valid = 2'b01;
            rsp_ready = 2'b11;
            #1;
            n = 0;
            while (req_ready[0] !== 1'b1 && n < 8) begin
                @(negedge clk);
                #1;
                n++;
            end
            checks++;
            if (req_ready[0] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL illegal_accept_%0d: got ready=%b expected 01", t, req_ready);
            end else begin
                sb.push_back('{0, tbl[t].result, tbl[t].illegal});
            end
            @(negedge clk);
            req_valid = 2'b00;
            #1;
            n = 0;
            while (rsp_valid == 2'b00 && n < 8) begin
                @(negedge clk);
                #1;
                n++;
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (rsp_valid !== 2'(1 << e.req) || rsp_result !== e.result || rsp_illegal !== e.illegal) begin
                    failures++;
                    $display("[TB] FAIL illegal_resp_%0d: got valid=%b result=%h illegal=%b expected %b %h %b",
                             t, rsp_valid, rsp_result, rsp_illegal, 2'(1 << e.req), e.result, e.illegal);
                end
            end
        end
    endtask

    task test_reset_mid_op;
        exp_t e;
        int   n;
        logic pulse;
        @(negedge clk);
        set_req(1, 4'h0, 32'd7, 32'd8);
        req_valid = 2'b10;
        rsp_ready = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            failures++;
            $display("[TB] FAIL rmid_accept: got %b expected 10", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        rst       = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rmid_exec: got busy=%b expected 1", busy);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 2'b00 || req_ready !== 2'b00 || busy !== 1'b0 ||
            rsp_result !== 32'h0 || rsp_illegal !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rmid_cleared: got valid=%b ready=%b busy=%b result=%h illegal=%b expected all 0",
                     rsp_valid, req_ready, busy, rsp_result, rsp_illegal);
        end
        pulse = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            if (rsp_valid != 2'b00) pulse = 1'b1;
        end
        checks++;
        if (pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rmid_no_resp: got pulse=%b expected 0", pulse);
        end
        @(negedge clk);
        set_req(0, 4'h0, 32'd1, 32'd1);
        set_req(1, 4'h0, 32'd9, 32'd9);
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("[TB] FAIL rmid_first_grant: got %b expected 01", req_ready);
        end else begin
            sb.push_back('{0, 32'd2, 1'b0});
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n = 0;
        while (rsp_valid == 2'b00 && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (rsp_valid !== 2'(1 << e.req) || rsp_result !== e.result) begin
                failures++;
                $display("[TB] FAIL rmid_resp: got valid=%b result=%h expected %b %h",
                         rsp_valid, rsp_result, 2'(1 << e.req), e.result);
            end
        end
    endtask

    // Scenario sequence followed by the single summary line
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add();
        test_round_robin();
        test_backpressure();
        test_shift_compare();
        test_illegal();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one instance of the 32-bit `alu` between up to four requesters (e.g. the integer pipe, address generation and a debug port). It uses a round-robin arbiter and valid/ready handshakes on both sides. Each granted request's operands are captured, executed through the shared `alu`, and the registered result is returned to the granted requester. The block sits between the requesting units and the `alu` instance, which it instantiates internally.

## Interface
- `NUM_REQ`, default 2: number of requesters; legal range 2..4.
- `clk  in  1`: single clock; all state updates on its rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `req_valid  in  NUM_REQ`: per-requester request valid.
- `req_ready  out  NUM_REQ`: per-requester accept; at most one bit high.
- `req_opr  in  4*NUM_REQ`: ALU opcode; requester i occupies bits [4i+3:4i].
- `req_a  in  32*NUM_REQ`: operand A; requester i occupies bits [32i+31:32i].
- `req_b  in  32*NUM_REQ`: operand B; same packing as `req_a`.
- `rsp_valid  out  NUM_REQ`: one-hot response valid to the granted requester.
- `rsp_ready  in  NUM_REQ`: per-requester response accept.
- `rsp_result  out  32`: ALU result, shared by all requesters and qualified by `rsp_valid`.
- `rsp_illegal  out  1`: high with `rsp_valid` when the captured opcode is not a defined ALU operation.
- `busy  out  1`: high in every state except IDLE.

## Operation
- The FSM has three states: IDLE, EXEC and RESP. Reset puts the FSM in IDLE.
- **IDLE**
  - If any `req_valid` bit is high, grant g is the first valid requester searching upward, with wrap-around, from `last_grant+1`.
  - `req_ready[g]` is driven high combinationally in the same cycle.
  - `opr`, `a`, `b` and g are captured into registers, and `last_grant` is set to g. The next state is EXEC.
  - If no `req_valid` bit is high, the FSM stays in IDLE.
- **EXEC**
  - The shared `alu` is driven from the captured registers.
  - Its output is registered into `rsp_result`.
  - `rsp_illegal` is set to 1 if the captured opcode is in {9,A,B,C,E,F}; the `alu` returns 0 for those opcodes.
  - The next state is RESP.
- **RESP**
  - `rsp_valid[g]` is 1; `rsp_result` and `rsp_illegal` are held stable.
  - If `rsp_ready[g]` is high, the FSM goes to IDLE. Otherwise it stays in RESP indefinitely.
  - `rsp_ready` bits of non-granted requesters are ignored.
- `req_ready` is 0 in every state except IDLE; no new request is accepted while an operation is outstanding.
- Requesters must hold `req_opr`/`req_a`/`req_b` stable while `req_valid` is high and `req_ready` is low.
- A requester may drop `req_valid` before it is granted; the arbiter takes no action for it.
- All arithmetic, width and shift semantics are those of `alu`: 32-bit wrap-around add/sub, shift amount `b[4:0]`, signed/unsigned SLT/SLTU.
- Reset, in any state including EXEC or RESP:
  - The FSM goes to IDLE; the outstanding operation is discarded and no response is issued.
  - `last_grant` is set to NUM_REQ-1, so requester 0 wins the first arbitration.

## Timing
- Reset values of outputs: `req_ready` = 0, `rsp_valid` = 0, `rsp_result` = 0, `rsp_illegal` = 0, `busy` = 0.
- Accept happens in cycle T, the IDLE handshake.
- Cycle T+1 is EXEC.
- In cycle T+2, `rsp_valid` goes high; the accept-to-response latency is 2 cycles.
- If `rsp_ready` is high in T+2, the FSM is in IDLE in T+3 and the next accept can occur in T+3.
- Peak throughput is one operation per 3 cycles.
- A response handshake (RESP→IDLE) and a new accept never occur in the same cycle.
- `rsp_result` and `rsp_illegal` change only on the EXEC→RESP edge and on reset.
- There are no combinational paths from `rsp_ready` to `req_ready` or to any other output.

## Test plan
1. ADD returns on time.
   - Stimulus: after reset, requester 0 sends opr=0000, a=5, b=7, with `rsp_ready` held high.
   - Required: `req_ready[0]` in cycle T; `rsp_valid`=01 and `rsp_result`=12 in T+2; `busy` low in T+3.
2. Round-robin fairness.
   - Stimulus: both requesters hold `req_valid` high continuously, with `rsp_ready` always high.
   - Required: grants follow the order 0,1,0,1; each grant is 3 cycles after the previous one.
3. Response backpressure.
   - Stimulus: requester 1 sends SUB, a=3, b=5, while `rsp_ready[1]` is held low for 5 cycles; requester 0 is valid throughout.
   - Required: `rsp_result`=0xFFFFFFFE is held for all 5 cycles; `req_ready` stays 00; requester 0 is granted the cycle after `rsp_ready[1]` rises.
4. Shift and compare opcodes.
   - SRA, a=0x80000000, b=4 → 0xF8000000.
   - SRL with the same operands → 0x08000000.
   - SLT, a=0xFFFFFFFF, b=1 → 1.
   - SLTU with the same operands → 0.
5. Illegal opcode.
   - Stimulus: opr=1111, a=1, b=1.
   - Required: `rsp_result`=0 and `rsp_illegal`=1 while `rsp_valid` is high; the next legal operation returns `rsp_illegal`=0.
6. Reset mid-operation.
   - Stimulus: assert `rst` during EXEC of a grant to requester 1.
   - Required: no `rsp_valid` pulse; all outputs are 0 in the cycle after `rst`; the first post-reset contention between requesters 0 and 1 grants 0.
